// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs a 32-bit big-endian word stream into 512-bit blocks,
// appends the 0x80 marker, zero fill and 64-bit bit length, and holds each block until acked.
module sha256_padder #(
   parameter int LEN_W = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [31:0]  in_data,
   input  logic         in_valid,
   input  logic         in_last,
   input  logic [1:0]   in_bytes,
   output logic         in_ready,
   output logic [511:0] block,
   output logic         block_valid,
   output logic         block_first,
   output logic         block_last,
   input  logic         block_ack
);

   // state | meaning
   // FILL  | collecting message words into the buffer
   // EMIT  | block presented to the core, waiting for block_ack
   // TAIL  | building the extra length-only block
   typedef enum logic [1:0] {FILL, EMIT, TAIL} state_t;

   state_t            state, state_nx;
   logic [31:0]       words [16];
   logic [3:0]        wcnt;
   logic [LEN_W-1:0]  len_cnt;
   logic [LEN_W-1:0]  len_nx;
   logic              tail_pend;
   logic              tail_mark;
   logic              first_q;
   logic              last_q;
   logic              accept;
   logic [2:0]        nbytes;
   logic [5:0]        add_bits;
   logic [31:0]       last_word;
   logic              full_word;
   logic              room;
   logic [63:0]       len64_nx;
   logic [63:0]       len64;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= FILL;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      in_ready    = 1'b0;
      block_valid = 1'b0;
      accept      = 1'b0;
      case (state)
         FILL: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept = 1'b1;
               if (in_last || wcnt == 4'd15) state_nx = EMIT;
            end
         end
         EMIT: begin
            block_valid = 1'b1;
            if (block_ack) state_nx = tail_pend ? TAIL : FILL;
         end
         TAIL:    state_nx = EMIT;
         default: state_nx = FILL;
      endcase
   end

   always_comb begin
      full_word = (in_bytes == 2'd0);
      nbytes    = full_word ? 3'd4 : {1'b0, in_bytes};
      add_bits  = in_last ? {nbytes, 3'b000} : 6'd32;
      len_nx    = len_cnt + LEN_W'(add_bits);
      len64_nx  = 64'(len_nx);
      len64     = 64'(len_cnt);
      // pad position p must leave words 14/15 free for the length
      room      = full_word ? (wcnt <= 4'd12) : (wcnt <= 4'd13);
      case (in_bytes)
         2'd1:    last_word = {in_data[31:24], 8'h80, 16'h0000};
         2'd2:    last_word = {in_data[31:16], 8'h80, 8'h00};
         2'd3:    last_word = {in_data[31:8], 8'h80};
         default: last_word = in_data;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) words[i] <= '0;
         wcnt      <= '0;
         len_cnt   <= '0;
         tail_pend <= 1'b0;
         tail_mark <= 1'b0;
         first_q   <= 1'b1;
         last_q    <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               if (accept) begin
                  len_cnt <= len_nx;
                  wcnt    <= wcnt + 4'd1;
                  if (in_last) begin
                     words[wcnt] <= last_word;
                     if (full_word && wcnt != 4'd15) words[wcnt + 4'd1] <= 32'h8000_0000;
                     if (room) begin
                        words[14] <= len64_nx[63:32];
                        words[15] <= len64_nx[31:0];
                        last_q    <= 1'b1;
                     end
                     tail_pend <= ~room;
                     tail_mark <= full_word && (wcnt == 4'd15);
                  end else begin
                     words[wcnt] <= in_data;
                  end
               end
            end
            EMIT: begin
               if (block_ack) begin
                  for (int i = 0; i < 16; i++) words[i] <= '0;
                  wcnt    <= '0;
                  last_q  <= 1'b0;
                  first_q <= ~tail_pend & last_q;
                  if (!tail_pend && last_q) len_cnt <= '0;
               end
            end
            TAIL: begin
               words[0]  <= tail_mark ? 32'h8000_0000 : 32'h0;
               words[14] <= len64[63:32];
               words[15] <= len64[31:0];
               last_q    <= 1'b1;
               tail_pend <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      block = '0;
      for (int i = 0; i < 16; i++) block[511 - 32*i -: 32] = words[i];
   end

   assign block_first = first_q;
   assign block_last  = last_q;

endmodule

// File: tb/tb_sha256_padder.sv
// Randomized bench for sha256_padder; expected blocks come from a byte-level SHA-256 padding model.
module tb_sha256_padder;

   typedef byte unsigned bq_t[$];
   typedef struct {
      logic [511:0] blk;
      bit           first;
      bit           last;
      bit           pre_tail;
      int           hold;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset;
   logic [31:0]  in_data;
   logic         in_valid;
   logic         in_last;
   logic [1:0]   in_bytes;
   logic         in_ready;
   logic [511:0] block;
   logic         block_valid;
   logic         block_first;
   logic         block_last;
   logic         block_ack;

   int           n_checks = 0;
   int           n_errors = 0;
   int           n_pushed = 0;
   int           n_acked  = 0;
   bit           done     = 1'b0;
   logic [511:0] first_blk;
   logic [511:0] last_blk;
   exp_t         exp_q[$];

   sha256_padder #(.LEN_W(64)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_last(in_last), .in_bytes(in_bytes), .in_ready(in_ready), .block(block),
      .block_valid(block_valid), .block_first(block_first), .block_last(block_last),
      .block_ack(block_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Padding as defined on bytes: msg | 0x80 | zeros to 56 mod 64 | 64-bit bit length.
   task automatic model_push(input bq_t msg, input int hold);
      bq_t         p;
      logic [63:0] bl;
      int          nblk, nwords, ndata;
      exp_t        e;
      p = msg;
      p.push_back(8'h80);
      while (p.size() % 64 != 56) p.push_back(8'h00);
      bl = 64'(msg.size()) * 64'd8;
      for (int j = 7; j >= 0; j--) p.push_back(bl[8*j +: 8]);
      nblk   = p.size() / 64;
      nwords = (msg.size() + 3) / 4;
      ndata  = (nwords + 15) / 16;
      for (int i = 0; i < nblk; i++) begin
         for (int j = 0; j < 64; j++) e.blk[511 - 8*j -: 8] = p[64*i + j];
         e.first    = (i == 0);
         e.last     = (i == nblk - 1);
         e.pre_tail = (nblk > ndata) && (i == nblk - 2);
         e.hold     = hold;
         exp_q.push_back(e);
         n_pushed++;
      end
   endtask

   task automatic drive_word(input logic [31:0] d, input bit last, input logic [1:0] nb,
                             input bit completes);
      int guard;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      in_bytes = nb;
      guard    = 0;
      while (!in_ready && guard < 2000) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 2000) begin
         check("in_ready_timeout", 1'b0, 1'b1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      if (completes) check("latency", block_valid, 1'b1);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_msg(input bq_t msg);
      int          nwords, idx;
      logic [31:0] d;
      bit          last;
      nwords = (msg.size() + 3) / 4;
      for (int w = 0; w < nwords; w++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
         for (int j = 0; j < 4; j++) begin
            idx = 4*w + j;
            d[31 - 8*j -: 8] = (idx < msg.size()) ? msg[idx] : 8'($urandom);
         end
         last = (w == nwords - 1);
         drive_word(d, last, last ? 2'(msg.size() % 4) : 2'($urandom), last || (w % 16 == 15));
      end
   endtask

   task automatic mk_msg(input int n, output bq_t q);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
   endtask

   task automatic run_msg(input bq_t msg, input int hold);
      model_push(msg, hold);
      send_msg(msg);
   endtask

   task automatic monitor();
      exp_t e;
      int   guard;
      forever begin
         guard = 0;
         while (!block_valid) begin
            if (done) return;
            @(posedge clk); #1;
            if (exp_q.size() != 0) guard++;
            else guard = 0;
            if (guard > 3000) begin
               check("block_timeout", 1'b0, 1'b1);
               return;
            end
         end
         if (exp_q.size() == 0) begin
            check("unexpected_block", 1'b1, 1'b0);
            e.blk = block; e.first = block_first; e.last = block_last;
            e.pre_tail = 1'b0; e.hold = 0;
         end else begin
            e = exp_q.pop_front();
         end
         if (n_acked == 0) first_blk = block;
         last_blk = block;
         check("block", block, e.blk);
         check("block_first", block_first, e.first);
         check("block_last", block_last, e.last);
         for (int h = 0; h < e.hold; h++) begin
            @(posedge clk); #1;
            check("hold_block", block, e.blk);
            check("hold_ready", in_ready, 1'b0);
            check("hold_valid", block_valid, 1'b1);
         end
         block_ack = 1'b1;
         @(posedge clk); #1;
         block_ack = 1'b0;
         if (e.pre_tail) begin
            check("tail_gap_valid", block_valid, 1'b0);
            check("tail_gap_ready", in_ready, 1'b0);
            @(posedge clk); #1;
            check("tail_valid", block_valid, 1'b1);
         end else begin
            check("ack_valid", block_valid, 1'b0);
            check("ack_ready", in_ready, 1'b1);
         end
         n_acked++;
      end
   endtask

   initial begin
      bq_t abc, m;
      int  guard;
      reset = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
      in_bytes = '0; block_ack = 1'b0;
      abc = {8'h61, 8'h62, 8'h63};
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_block_valid", block_valid, 1'b0);
      check("rst_block", block, '0);
      check("rst_block_first", block_first, 1'b1);
      check("rst_block_last", block_last, 1'b0);
      reset = 1'b0;
      fork monitor(); join_none

      run_msg(abc, 1);
      mk_msg(55, m); run_msg(m, 2);
      mk_msg(56, m); run_msg(m, 0);
      mk_msg(64, m); run_msg(m, 1);
      mk_msg(60, m); run_msg(m, 0);
      run_msg(abc, 10);
      run_msg(abc, 0);
      for (int i = 0; i < 10; i++) begin
         mk_msg($urandom_range(1, 150), m);
         run_msg(m, $urandom_range(0, 3));
      end

      guard = 0;
      while (n_acked != n_pushed && guard < 5000) begin
         @(posedge clk); #1;
         guard++;
      end
      check("drain", 32'(n_acked), 32'(n_pushed));

      // abandon a message after 7 words with an asynchronous reset pulse
      for (int w = 0; w < 7; w++) drive_word($urandom, 1'b0, 2'($urandom), 1'b0);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_valid", block_valid, 1'b0);
      check("mid_rst_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check("post_rst_valid", block_valid, 1'b0);
      end
      run_msg(abc, 0);

      guard = 0;
      while (n_acked != n_pushed && guard < 5000) begin
         @(posedge clk); #1;
         guard++;
      end
      check("drain_after_reset", 32'(n_acked), 32'(n_pushed));
      done = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("abc_word0", first_blk[511:480], 32'h6162_6380);
      check("abc_word15", first_blk[31:0], 32'h0000_0018);
      check("abc_words1_14", first_blk[479:32], '0);
      check("abc_after_reset", last_blk[511:480], 32'h6162_6380);
      check("abc_after_reset_len", last_blk[31:0], 32'h0000_0018);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
